// File: rtl/booth_multiplier_u16.sv
// Unsigned WIDTHxWIDTH multiplier: radix-4 Booth partial products, 3:2 carry-save
// reduction, Kogge-Stone final adder, and one output register.
module booth_multiplier_u16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [2*WIDTH-1:0]   result,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y
);

    localparam int PW  = 2 * WIDTH;
    localparam int ND  = WIDTH / 2 + 1;   // last digit is the unsigned correction digit
    localparam int NR  = ND + 1;          // partial products plus one row of negation bits
    localparam int LOG = $clog2(PW);

    // Row count after a given number of 3:2 levels.
    function automatic int rows_after(input int lvl);
        int n;
        n = NR;
        for (int l = 0; l < lvl; l++) begin
            n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int num_levels();
        int n;
        int l;
        n = NR;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NLVL = num_levels();

    // Full-adder row: returns {carry << 1, sum}; the carry out of the top bit is dropped.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] c);
        logic [PW-1:0] s;
        logic [PW-1:0] m;
        s = a ^ b ^ c;
        m = (a & b) | (a & c) | (b & c);
        return {m[PW-2:0], 1'b0, s};
    endfunction

    logic [PW-1:0] pp_rows [NR];
    logic [PW-1:0] row_a;
    logic [PW-1:0] row_b;
    logic [PW-1:0] prod_p0;

    // Booth recoding over y zero-extended with the implicit y[-1] = 0.
    // Negative digits use ~mag sign-extended with the digit's sign; the +1 goes into a separate row.
    always_comb begin
        logic [WIDTH+2:0] ye;
        logic [2:0]       t;
        logic             one;
        logic             two;
        logic             neg;
        logic [WIDTH:0]   mag;
        logic [PW-1:0]    ext;
        logic [PW-1:0]    negbits;
        ye      = {2'b00, y, 1'b0};
        t       = '0;
        one     = 1'b0;
        two     = 1'b0;
        neg     = 1'b0;
        mag     = '0;
        ext     = '0;
        negbits = '0;
        for (int r = 0; r < NR; r++) begin
            pp_rows[r] = '0;
        end
        for (int i = 0; i < ND; i++) begin
            t   = ye[2*i +: 3];
            one = t[0] ^ t[1];
            two = (t == 3'b011) || (t == 3'b100);
            neg = t[2] & ~(t[1] & t[0]);
            mag = one ? {1'b0, x} : (two ? {x, 1'b0} : '0);
            ext = {{(PW-WIDTH-1){neg}}, mag ^ {(WIDTH+1){neg}}};
            pp_rows[i]     = ext << (2 * i);
            negbits[2*i]   = neg;
        end
        pp_rows[NR-1] = negbits;
    end

    // Wallace-style reduction: each level compresses groups of three rows, leftovers pass through.
    always_comb begin
        logic [PW-1:0]   cur [NR];
        logic [PW-1:0]   nxt [NR];
        logic [2*PW-1:0] sc;
        int              n;
        int              ng;
        cur = pp_rows;
        nxt = pp_rows;
        sc  = '0;
        n   = NR;
        ng  = 0;
        for (int l = 0; l < NLVL; l++) begin
            n  = rows_after(l);
            ng = n / 3;
            for (int r = 0; r < NR; r++) begin
                nxt[r] = '0;
            end
            for (int g = 0; g < NR / 3; g++) begin
                if (g < ng) begin
                    sc         = csa(cur[3*g], cur[3*g+1], cur[3*g+2]);
                    nxt[2*g]   = sc[PW-1:0];
                    nxt[2*g+1] = sc[2*PW-1:PW];
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < n % 3) begin
                    nxt[2*ng+r] = cur[3*ng+r];
                end
            end
            cur = nxt;
        end
        row_a = cur[0];
        row_b = cur[1];
    end

    // Kogge-Stone prefix: level l combines (g,p) with the cell 2^l positions below.
    always_comb begin
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [PW-1:0] gn;
        logic [PW-1:0] pn;
        logic [PW-1:0] p0;
        g  = row_a & row_b;
        p  = row_a ^ row_b;
        p0 = p;
        gn = g;
        pn = p;
        for (int l = 0; l < LOG; l++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < PW; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
                    pn[i] = p[i] & p[i-(1<<l)];
                end
            end
            g = gn;
            p = pn;
        end
        prod_p0 = p0 ^ {g[PW-2:0], 1'b0};
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= prod_p0;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_u16.sv
// Scoreboard bench for booth_multiplier_u16: stimulus pushes expected products,
// a monitor pops and compares one per clock while out of reset.
module tb_booth_multiplier_u16;

    typedef struct {
        logic [31:0] exp;
        logic [15:0] xa;
        logic [15:0] ya;
        string       tag;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x   = 16'd1234;
    logic [15:0] y   = 16'd5678;
    logic [31:0] result;

    item_t sb[$];
    item_t it;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    booth_multiplier_u16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .x      (x),
        .y      (y)
    );

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    task automatic check_now(input string tag, input logic [31:0] exp);
        n_cmp++;
        if (result !== exp) begin
            n_bad++;
            $display("FAIL %s: result=%0d expected=%0d", tag, result, exp);
        end
    endtask

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp, input string tag);
        @(negedge clk);
        x = a;
        y = b;
        sb.push_back('{exp: exp, xa: a, ya: b, tag: tag});
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input string tag);
        issue_exp(a, b, model(a, b), tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            it = sb.pop_front();
            n_cmp++;
            if (result !== it.exp) begin
                n_bad++;
                $display("FAIL %s: x=%0d y=%0d result=%0d expected=%0d",
                         it.tag, it.xa, it.ya, result, it.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] a;
        logic [15:0] b;

        #1;
        check_now("reset_async_initial", 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_now("reset_hold", 32'd0);
        end

        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{exp: 32'd7006652, xa: x, ya: y, tag: "reset_release"});
        #1;
        check_now("no_load_on_release", 32'd0);

        issue_exp(16'd0,     16'd0,     32'd0,          "corner_0x0");
        issue_exp(16'd65535, 16'd1,     32'd65535,      "corner_max_x1");
        issue_exp(16'd65535, 16'd65535, 32'd4294836225, "corner_max_max");
        issue_exp(16'd32768, 16'd2,     32'd65536,      "corner_msb_x2");
        issue_exp(16'd43690, 16'd21845, 32'd954408050,  "booth_alt");
        issue_exp(16'd1000,  16'd1000,  32'd1000000,    "booth_1000sq");
        issue_exp(16'd65000, 16'd3,     32'd195000,     "booth_x3");
        issue_exp(16'd12345, 16'd0,     32'd0,          "y_zero");
        issue_exp(16'd65535, 16'd32768, 32'd2147450880, "y_bit15");
        issue_exp(16'd65535, 16'd2,     32'd131070,     "neg2_msb");

        // Async reset between edges, then release and resume.
        issue(16'd50000, 16'd40000, "pre_async");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_now("async_mid_clear", 32'd0);
        @(negedge clk);
        check_now("async_mid_hold", 32'd0);
        x   = 16'd777;
        y   = 16'd999;
        rst = 1'b0;
        sb.push_back('{exp: 32'd776223, xa: 16'd777, ya: 16'd999, tag: "async_release"});

        for (int i = 0; i <= 65000; i += 1000) begin
            for (int j = 0; j <= 65000; j += 1000) begin
                issue(16'(i), 16'(j), "sweep");
            end
        end

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            a = r[15:0];
            b = r[31:16];
            case (k % 8)
                0: a = 16'hFFFF;
                1: b = b | 16'h8000;
                2: b = 16'hAAAA ^ r[31:16];
                default: ;
            endcase
            issue(a, b, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
